// File: rtl/ins_mem_loader_if.sv
// Host-side word stream plus instruction-memory byte write port for the loader.
// slave is the loader's view; master is the host/memory side.
interface ins_mem_loader_if #(parameter int ADDR_W = 32);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              word_valid;
  logic [31:0]       word_data;
  logic              word_last;
  logic              word_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              busy;
  logic              done;
  logic              error;

  modport slave (
    input  start, base_addr, word_valid, word_data, word_last,
    output word_ready, mem_we, mem_addr, mem_wdata, busy, done, error
  );

  modport master (
    output start, base_addr, word_valid, word_data, word_last,
    input  word_ready, mem_we, mem_addr, mem_wdata, busy, done, error
  );
endinterface

// File: rtl/ins_mem_loader.sv
// Streams 32-bit instruction words into byte-wide instruction memory, MSB byte at the lowest address.
// One WAIT cycle accepts a word, then four WRITE cycles emit its bytes.
module ins_mem_loader #(
  parameter int SIZE   = 256,
  parameter int ADDR_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  ins_mem_loader_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, WAIT, WRITE, ERROR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [23:0]       sh;
  logic [1:0]        k;
  logic              last_q;
  logic [ADDR_W:0]   end_a;
  logic              fits;

  // Extra bit so a base near the top of the address space cannot wrap into range.
  assign end_a = {1'b0, addr} + (ADDR_W+1)'(3);
  assign fits  = end_a <= (ADDR_W+1)'(SIZE - 1);

  assign bus.word_ready = (state == WAIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      addr          <= '0;
      sh            <= '0;
      k             <= '0;
      last_q        <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.error     <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE, ERROR: begin
          if (bus.start) begin
            if (bus.base_addr[1:0] != 2'b00) begin
              state     <= ERROR;
              bus.error <= 1'b1;
            end else begin
              addr      <= bus.base_addr;
              state     <= WAIT;
              bus.busy  <= 1'b1;
              bus.error <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (bus.word_valid) begin
            if (fits) begin
              state         <= WRITE;
              k             <= 2'd0;
              last_q        <= bus.word_last;
              sh            <= bus.word_data[23:0];
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= addr;
              bus.mem_wdata <= bus.word_data[31:24];
            end else begin
              // Word would cross the top of memory: drop it and write nothing.
              state     <= ERROR;
              bus.error <= 1'b1;
              bus.busy  <= 1'b0;
            end
          end
        end
        WRITE: begin
          if (k == 2'd3) begin
            bus.mem_we <= 1'b0;
            addr       <= addr + ADDR_W'(4);
            if (last_q) begin
              state    <= IDLE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end else begin
            k             <= k + 2'd1;
            bus.mem_addr  <= bus.mem_addr + ADDR_W'(1);
            bus.mem_wdata <= sh[23:16];
            sh            <= {sh[15:0], 8'h00};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ins_mem_loader.sv
// Scoreboarded bench for ins_mem_loader: expected byte writes are queued when a word is
// handed over and checked against mem_we/mem_addr/mem_wdata as they appear.
module tb_ins_mem_loader;
  localparam int SIZE   = 256;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ins_mem_loader_if #(.ADDR_W(ADDR_W)) bif ();
  ins_mem_loader #(.SIZE(SIZE), .ADDR_W(ADDR_W)) dut (.clk(clk), .reset(reset), .bus(bif));

  int n_chk = 0;
  int n_err = 0;
  logic [39:0] exp_q[$];   // {addr[31:0], byte}
  logic [31:0] exp_addr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Byte-write monitor against the scoreboard.
  always @(negedge clk) begin
    if (bif.mem_we === 1'b1) begin
      check("we_in_range", 64'(bif.mem_addr < SIZE), 64'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", 64'(bif.mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(bif.mem_addr), 64'(e[39:8]));
        check("wr_data", 64'(bif.mem_wdata), 64'(e[7:0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, 64'(bif.word_ready), 64'd0);
    check({tag, "_we"},    64'(bif.mem_we),     64'd0);
    check({tag, "_addr"},  64'(bif.mem_addr),   64'd0);
    check({tag, "_wdata"}, 64'(bif.mem_wdata),  64'd0);
    check({tag, "_busy"},  64'(bif.busy),       64'd0);
    check({tag, "_done"},  64'(bif.done),       64'd0);
    check({tag, "_error"}, 64'(bif.error),      64'd0);
  endtask

  task automatic do_start(input logic [31:0] base);
    bif.start = 1'b1;
    bif.base_addr = base;
    tick();
    bif.start = 1'b0;
    if (base[1:0] == 2'b00) exp_addr = base;
  endtask

  // Offer a word and wait for the handshake; nbytes of it are expected to be written.
  // word_valid is left high so back-to-back calls model a continuously valid source.
  task automatic send_word(input logic [31:0] data, input logic last, input int nbytes,
                           output int waits);
    bif.word_valid = 1'b1;
    bif.word_data  = data;
    bif.word_last  = last;
    waits = 0;
    while (bif.word_ready !== 1'b1 && waits < 50) begin
      tick();
      waits++;
    end
    if (waits >= 50) check("ready_timeout", 64'd0, 64'd1);
    for (int b = 0; b < nbytes; b++)
      exp_q.push_back({exp_addr + 32'(b), data[31-8*b -: 8]});
    if (nbytes > 0) exp_addr = exp_addr + 32'd4;
    tick();
  endtask

  // Called right after the last word's handshake: done must follow the fourth byte.
  task automatic wait_done(input string tag);
    int n = 0;
    while (bif.done !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_done_lat"}, 64'(n), 64'd4);
    check({tag, "_busy_at_done"}, 64'(bif.busy), 64'd0);
    tick();
    check({tag, "_done_width"}, 64'(bif.done), 64'd0);
  endtask

  initial begin
    int w;
    reset = 1'b1;
    bif.start = 1'b0; bif.base_addr = '0;
    bif.word_valid = 1'b0; bif.word_data = '0; bif.word_last = 1'b0;
    exp_addr = '0;
    tick(); tick();
    check_reset_vals("rst");
    reset = 1'b0;
    tick();

    // 1: basic two-word session
    do_start(32'd0);
    check("t1_busy", 64'(bif.busy), 64'd1);
    check("t1_ready", 64'(bif.word_ready), 64'd1);
    send_word(32'h2008_0005, 1'b0, 4, w);
    send_word(32'h8C09_0004, 1'b1, 4, w);
    bif.word_valid = 1'b0;
    check("t1_first_lat", 64'(bif.mem_we), 64'd1);
    wait_done("t1");
    check("t1_ready_idle", 64'(bif.word_ready), 64'd0);

    // 2: continuously valid source, ready pattern 1,0,0,0,0
    do_start(32'd64);
    send_word(32'h0101_0101, 1'b0, 4, w);
    for (int i = 0; i < 3; i++) begin
      send_word($urandom, 1'b0, 4, w);
      check("t2_ready_gap", 64'(w), 64'd4);
    end
    send_word(32'hA5A5_5A5A, 1'b1, 4, w);
    check("t2_ready_gap_last", 64'(w), 64'd4);
    bif.word_valid = 1'b0;
    wait_done("t2");

    // 3: boundary - final word ends exactly at SIZE-1, then overflow
    do_start(32'd252);
    send_word(32'hDEAD_BEEF, 1'b1, 4, w);
    bif.word_valid = 1'b0;
    wait_done("t3a");
    check("t3a_error", 64'(bif.error), 64'd0);
    do_start(32'd252);
    send_word(32'hDEAD_BEEF, 1'b0, 4, w);
    send_word(32'hCAFE_F00D, 1'b1, 0, w);
    bif.word_valid = 1'b0;
    check("t3b_error", 64'(bif.error), 64'd1);
    check("t3b_busy", 64'(bif.busy), 64'd0);
    tick(); tick();
    check("t3b_error_sticky", 64'(bif.error), 64'd1);

    // 4: misaligned start, valid ignored, then recovery
    do_start(32'd0);
    check("t4_good_clears", 64'(bif.error), 64'd0);
    reset = 1'b1; tick(); reset = 1'b0;
    do_start(32'd2);
    check("t4_error", 64'(bif.error), 64'd1);
    check("t4_busy", 64'(bif.busy), 64'd0);
    bif.word_valid = 1'b1;
    tick();
    check("t4_ready_err", 64'(bif.word_ready), 64'd0);
    tick();
    bif.word_valid = 1'b0;
    do_start(32'd8);
    check("t4_error_clr", 64'(bif.error), 64'd0);
    check("t4_busy2", 64'(bif.busy), 64'd1);
    send_word(32'h1234_5678, 1'b1, 4, w);
    bif.word_valid = 1'b0;
    wait_done("t4");

    // 5: reset while byte 1 of a word is on the port
    do_start(32'd16);
    send_word(32'h1122_3344, 1'b1, 2, w);
    bif.word_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check_reset_vals("t5");
    reset = 1'b0;
    tick();
    do_start(32'd20);
    send_word(32'h5566_7788, 1'b1, 4, w);
    bif.word_valid = 1'b0;
    wait_done("t5");

    // 6: start during WRITE is ignored
    do_start(32'd32);
    send_word(32'h99AA_BBCC, 1'b0, 4, w);
    bif.word_valid = 1'b0;
    tick();
    bif.start = 1'b1; bif.base_addr = 32'd100;
    tick();
    bif.start = 1'b0;
    send_word(32'hDDEE_FF00, 1'b1, 4, w);
    bif.word_valid = 1'b0;
    wait_done("t6");

    tick(); tick();
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
